// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: default widths, settle
// counter width and the FSM state encoding.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 5;
  localparam int OP_W_DEF   = 4;
  localparam int CNT_W      = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_settle_cnt.sv
// Settle-time down-counter: loaded on command acceptance, counts down while
// the ALU output settles, flags terminal count.
module alu_seq_settle_cnt
  import alu_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues opcode/operands to an external ALU, waits SETTLE_CYC cycles, returns
// the sampled result. Define ALU_OP_SEQUENCER_PERF_EN for a live op_count.
//
// state | meaning
// IDLE  | ready for a command, ALU inputs hold the last issued values
// WAIT  | ALU inputs driven, settle counter running
// DONE  | result held on res_data_o until the consumer takes it
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OP_W       = OP_W_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic              cmd_use_acc_i,
  input  logic              acc_clr_i,
  output logic [OP_W-1:0]   alu_s_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_y_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [15:0]       op_count_o
);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [OP_W-1:0]   alu_s_q, alu_s_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  logic             accept;
  logic             res_hs;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  assign accept = cmd_valid_i && cmd_ready_q && (state_q == ST_IDLE);
  assign res_hs = res_valid_q && res_ready_i && (state_q == ST_DONE);

  alu_seq_settle_cnt u_settle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .load_val_i (CNT_W'(SETTLE_CYC - 1)),
    .dec_i      ((state_q == ST_WAIT) && (cnt_val != '0)),
    .value_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    alu_s_d     = alu_s_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    acc_d       = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_s_d = cmd_op_i;
          alu_a_d = cmd_use_acc_i ? acc_q : cmd_a_i;
          alu_b_d = cmd_b_i;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          res_data_d  = alu_y_i;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_hs) begin
          res_valid_d = 1'b0;
          acc_d       = res_data_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear beats a coinciding result load; acceptance already sampled acc_q.
    if (acc_clr_i) begin
      acc_d = '0;
    end
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      acc_q       <= acc_d;
    end
  end

`ifdef ALU_OP_SEQUENCER_PERF_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_count_q <= '0;
    end else if (res_hs) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count_o = op_count_q;
`else
  assign op_count_o = '0;
`endif

  assign cmd_ready_o = cmd_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign alu_s_o     = alu_s_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Issuing end of the ALU interface. Accepts operation commands (opcode plus two operands) over a valid/ready handshake, drives the ALU's S/A/B inputs, waits a fixed settle time, and captures the ALU result. It returns the result over a second valid/ready handshake. An internal accumulator lets a command reuse the previous result as operand A, so the ALU can be chained without the host re-sending data.

Parameters:
DATA_W, 5, operand/result width; matches the ALU's A, B and Alu ports.
OP_W, 4, opcode width; matches the ALU's S port.
SETTLE_CYC, 1, cycles between driving the ALU and sampling its result; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  OP_W  opcode to issue
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
cmd_use_acc  input  1  1 = use accumulator instead of cmd_a
acc_clr  input  1  clear accumulator to 0
alu_s  output  OP_W  to ALU S
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_y  input  DATA_W  from ALU Alu
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  DATA_W  captured result
op_count  output  16  completed-operation count (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- On rst: state=IDLE, and the following are all 0: cmd_ready, res_valid, res_data, alu_s/alu_a/alu_b, acc, settle counter and op_count. cmd_ready goes to 1 on the first cycle after rst deasserts.
- A reset mid-operation aborts the operation. Any in-flight command or unaccepted result is discarded.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register alu_s=cmd_op, alu_a=(cmd_use_acc ? acc : cmd_a) and alu_b=cmd_b.
  - Load cnt=SETTLE_CYC-1 and go to WAIT.
- WAIT:
  - cmd_ready=0.
  - If cnt≠0, decrement cnt.
  - If cnt=0, register res_data=alu_y, set res_valid=1 and go to DONE.
- DONE:
  - res_valid held at 1 and res_data held stable until res_ready=1.
  - On handshake: res_valid←0, acc←res_data, op_count++, go to IDLE.
- alu_s/alu_a/alu_b hold their values outside command acceptance. The ALU inputs stay stable for the entire WAIT+DONE period.
- Latency:
  - A command accepted at edge t gives res_valid=1 after edge t+SETTLE_CYC.
  - Throughput with res_ready tied high is one op per SETTLE_CYC+2 cycles.
- res_ready high before res_valid has no effect. The handshake completes only in a cycle where both are 1.
- acc_clr:
  - Forces acc←0 in any state.
  - If it coincides with a result handshake, clear wins.
  - If it coincides with a cmd_use_acc acceptance, the acc value from before the clear is used, then acc is cleared.
- cmd_valid while busy is ignored. The host must hold the command until it sees cmd_ready.
- Arithmetic: no arithmetic is performed internally. op_count wraps from 0xFFFF to 0.

Optional Feature:
- Macro ALU_OP_SEQUENCER_PERF_EN.
- Defined: op_count is a live 16-bit counter of result handshakes, cleared by rst.
- Undefined: op_count is tied to 0, and the counter register is not present in synthesis.
- All other behaviour is identical in both builds.

Decomposition:
- Package alu_seq_pkg holds:
  - DATA_W and OP_W defaults.
  - The FSM state enumeration (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
  - Counter width constant CNT_W=4.
- The settle counter is a natural sub-module: alu_seq_settle_cnt, with load/value/zero outputs.
- Everything else stays in the top module.

Test Plan:
- Bench stub ALU computes alu_y=(alu_a+alu_b) mod 32. Reset, then cmd_op=4'b1101, cmd_a=5'b10101, cmd_b=5'b01100 -> alu_s=1101, res_data=5'b00001, res_valid exactly SETTLE_CYC cycles after acceptance.
- Chain: first result 00001 taken, then cmd_use_acc=1, cmd_b=00011 -> alu_a=00001, res_data=00100.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0, a second cmd_valid is not accepted. Release -> single handshake, then cmd_ready=1 next cycle.
- Assert rst during WAIT -> next cycle all outputs 0 and state IDLE; no res_valid pulse ever appears for the aborted op.
- acc_clr coincident with a result handshake -> acc=0. A following cmd_use_acc command with cmd_b=00111 -> res_data=00111.
- With ALU_OP_SEQUENCER_PERF_EN: run 3 ops -> op_count=3; reset -> 0. Without the macro: op_count=0 throughout.
